sig_debounce: RTL and testbench
===============================

// Module: sig_debounce
// PURPOSE
//   Debounces one asynchronous, bouncy input (switch, float sensor, push button).
//   - Synchronises the input into the clk domain.
//   - Passes a new level to the output only after it has been stable for DEB_CYCLES consecutive clocks.
//   - Also emits single-cycle rise/fall strobes for downstream control logic.
//   - Sits between raw board I/O and the monitor's control FSMs.
// PARAMETERS
//   SYNC_STAGES  2   synchroniser flop count; must be >=2
//   DEB_CYCLES   16  consecutive stable synced cycles required to accept a new level; must be >=1
//   RST_VAL      0   level of sync flops and sig_o while in reset
// PORTS
//   clk     in   1  system clock, rising-edge
//   rst_n   in   1  asynchronous, active-low reset
//   sig_i   in   1  raw asynchronous input, may glitch at any rate
//   sig_o   out  1  debounced level, registered
//   rise_o  out  1  1-cycle pulse when sig_o goes 0->1
//   fall_o  out  1  1-cycle pulse when sig_o goes 1->0
// BEHAVIOUR
//   - Single clock domain. Reset is asynchronous and active-low (rst_n).
//   - Reset state:
//       - all sync flops = RST_VAL; sig_o = RST_VAL
//       - counter = 0; rise_o = fall_o = 0
//   - Release from reset takes effect on the first clk edge after rst_n goes high.
//   - Synchroniser: sig_i passes through SYNC_STAGES flops; the last stage is s.
//   - Counter: unsigned, width $clog2(DEB_CYCLES+1), counts consecutive cycles with s != sig_o.
//   - Per rising edge:
//       - s == sig_o: counter <= 0; sig_o holds.
//       - s != sig_o and counter == DEB_CYCLES-1: sig_o <= s; counter <= 0.
//       - s != sig_o otherwise: counter <= counter+1.
//   - Mismatch is measured against sig_o, not against the previous s. Any cycle with s == sig_o
//     (bounce back) restarts qualification from zero.
//   - Latency: a change of sig_i held stable from sampling edge 1 appears on sig_o at
//     edge SYNC_STAGES+DEB_CYCLES (18 with defaults).
//       - Input pulses shorter than DEB_CYCLES synced cycles never reach sig_o.
//       - Sub-period glitches between edges are invisible.
//   - rise_o / fall_o:
//       - registered, asserted for exactly the one cycle in which sig_o has just changed,
//         coincident with the new sig_o value
//       - never both high; no pulse out of reset
//   - Counter never exceeds DEB_CYCLES-1 and never wraps.
//   - DEB_CYCLES=1: accepts the new level on the first mismatching edge.
//   - rst_n asserted mid-count: counter is discarded immediately and sig_o returns to RST_VAL.
//     After release, qualification restarts from 0.
//   - Input held constant forever: no output activity, no strobes.
// STRUCTURE
//   - Package sig_deb_pkg holds:
//       - DEB_CYCLES_DEF = 16
//       - SYNC_STAGES_DEF = 2
//       - helper function cnt_w(n) = $clog2(n+1)
//   - Sub-module sync_ff:
//       - parameterised SYNC_STAGES, with async active-low reset to RST_VAL
//       - instantiated once
//   - The counter/output logic stays in sig_debounce.
// TESTING (clk period 10 ns, defaults unless noted)
//   1. Reset: rst_n=0 with sig_i toggling.
//        -> sig_o=0, rise_o=fall_o=0 throughout; no strobe on release.
//   2. Glitch train: sig_i toggles every 2 ns for 10 ns, then low.
//        -> sig_o stays 0, no strobes.
//   3. Stable high for 800 ns (80 clocks).
//        -> sig_o rises on edge 18 after the first sampling edge; rise_o high for 1 cycle.
//   4. While high, sig_i drops low for 5 ns, then high again.
//        -> sig_o stays 1, fall_o stays 0.
//   5. DEB_CYCLES=4:
//        -> low pulse of 3 clocks is ignored.
//        -> low pulse of 4 clocks gives sig_o=0 for exactly as long as the input stays low
//           past qualification, with one fall_o pulse.
//   6. rst_n pulsed low when counter=10.
//        -> sig_o=0 immediately; after release, a full 16 stable cycles are required again.

Source files
------------

// File: rtl/sig_deb_pkg.sv
// Shared defaults and sizing helper for the sig_debounce input conditioner.
`timescale 1ns/1ps
package sig_deb_pkg;

  localparam int DEB_CYCLES_DEF  = 16;
  localparam int SYNC_STAGES_DEF = 2;

  // Counter width able to hold the values 0..n.
  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/sync_ff.sv
// Multi-flop synchroniser bringing one asynchronous bit into the clk domain.
`timescale 1ns/1ps
module sync_ff
  import sig_deb_pkg::*;
#(
  parameter int   SYNC_STAGES = SYNC_STAGES_DEF,
  parameter logic RST_VAL     = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] stages;

  // NOTE: non-blocking assignments keep every flop sampling the pre-edge value,
  // so the chain shifts by exactly one stage per clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stages <= {SYNC_STAGES{RST_VAL}};
    end else begin
      stages <= {stages[SYNC_STAGES-2:0], d};
    end
  end

  assign q = stages[SYNC_STAGES-1];

endmodule

// File: rtl/sig_debounce.sv
// Debouncer: synchronise a bouncy input, accept a new level only after it has
// differed from the current output for DEB_CYCLES consecutive clocks.
`timescale 1ns/1ps
module sig_debounce
  import sig_deb_pkg::*;
#(
  parameter int   SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int   DEB_CYCLES  = DEB_CYCLES_DEF,
  parameter logic RST_VAL     = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sig_i,
  output logic sig_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int            CW       = cnt_w(DEB_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

  logic          s;
  logic [CW-1:0] cnt;

  sync_ff #(
    .SYNC_STAGES (SYNC_STAGES),
    .RST_VAL     (RST_VAL)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (sig_i),
    .q     (s)
  );

  // Mismatch is measured against the accepted level, so any bounce back to
  // sig_o restarts qualification from zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig_o  <= RST_VAL;
      cnt    <= '0;
      rise_o <= 1'b0;
      fall_o <= 1'b0;
    end else begin
      rise_o <= 1'b0;
      fall_o <= 1'b0;
      if (s == sig_o) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        sig_o  <= s;
        cnt    <= '0;
        rise_o <= s;
        fall_o <= ~s;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_sig_debounce.sv
// Bench for sig_debounce: two instances (16 and 4 qualification cycles) checked
// every cycle against a history-based model, plus hand-computed latency pins.
`timescale 1ns/1ps
module tb_sig_debounce;
  import sig_deb_pkg::*;

  localparam int SYNC = SYNC_STAGES_DEF;
  localparam int D16  = DEB_CYCLES_DEF;
  localparam int D4   = 4;

  logic clk, rst_n, sig_i;
  logic sig_o [2];
  logic rise_o[2];
  logic fall_o[2];

  sig_debounce #(.DEB_CYCLES(D16)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .sig_i(sig_i),
    .sig_o(sig_o[0]), .rise_o(rise_o[0]), .fall_o(fall_o[0])
  );

  sig_debounce #(.DEB_CYCLES(D4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .sig_i(sig_i),
    .sig_o(sig_o[1]), .rise_o(rise_o[1]), .fall_o(fall_o[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the output flips once the last D levels seen by the
  // qualifier all differ from the current output. The level seen at an edge is
  // the raw input sampled SYNC edges earlier (reset level before that).
  int deb_c[2] = '{D16, D4};
  bit raw_q [2][$];
  bit seen_q[2][$];
  bit m_sig [2];
  bit m_rise[2];
  bit m_fall[2];

  function automatic void model_reset();
    for (int i = 0; i < 2; i++) begin
      raw_q[i].delete();
      seen_q[i].delete();
      m_sig[i]  = 1'b0;
      m_rise[i] = 1'b0;
      m_fall[i] = 1'b0;
    end
  endfunction

  function automatic void model_edge(input bit x);
    for (int i = 0; i < 2; i++) begin
      bit seen;
      bit flip;
      int n;
      n    = raw_q[i].size();
      seen = (n >= SYNC) ? raw_q[i][n-SYNC] : 1'b0;
      raw_q[i].push_back(x);
      if (raw_q[i].size() > SYNC) void'(raw_q[i].pop_front());
      seen_q[i].push_back(seen);
      if (seen_q[i].size() > deb_c[i]) void'(seen_q[i].pop_front());
      m_rise[i] = 1'b0;
      m_fall[i] = 1'b0;
      flip = (seen_q[i].size() == deb_c[i]);
      for (int j = 0; j < seen_q[i].size(); j++)
        if (seen_q[i][j] == m_sig[i]) flip = 1'b0;
      if (flip) begin
        m_sig[i]  = !m_sig[i];
        m_rise[i] = m_sig[i];
        m_fall[i] = !m_sig[i];
      end
    end
  endfunction

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else        model_edge(sig_i);
    end
  end

  int edge_no = 0;
  initial forever begin
    @(posedge clk);
    edge_no++;
  end

  int rise_cnt [2] = '{0, 0};
  int fall_cnt [2] = '{0, 0};
  int last_rise[2] = '{0, 0};
  int last_fall[2] = '{0, 0};

  initial forever begin
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("dut%0d.sig_o",  deb_c[i]), 32'(sig_o[i]),  32'(m_sig[i]));
      check($sformatf("dut%0d.rise_o", deb_c[i]), 32'(rise_o[i]), 32'(m_rise[i]));
      check($sformatf("dut%0d.fall_o", deb_c[i]), 32'(fall_o[i]), 32'(m_fall[i]));
      if (rise_o[i] === 1'b1) begin rise_cnt[i]++; last_rise[i] = edge_no; end
      if (fall_o[i] === 1'b1) begin fall_cnt[i]++; last_fall[i] = edge_no; end
    end
  end

  task automatic wait_rise(input int i, input int base);
    int n = 0;
    while (rise_cnt[i] == base && n < 60) begin
      @(negedge clk);
      #1;
      n++;
    end
  endtask

  initial begin
    int e0, b0, b1, fb0, fb1, low_cnt, len;
    bit v;
    rst_n = 1'b0;
    sig_i = 1'b0;

    // Reset held while the input toggles; release must not strobe.
    repeat (8) begin
      @(posedge clk);
      #2 sig_i = 1'($urandom_range(0, 1));
      #4 sig_i = 1'($urandom_range(0, 1));
    end
    @(posedge clk);
    #2 sig_i = 1'b0;
    #1 rst_n = 1'b1;
    repeat (25) @(posedge clk);
    #1;
    check("t1_rise16", rise_cnt[0] + fall_cnt[0], 0);
    check("t1_rise4",  rise_cnt[1] + fall_cnt[1], 0);

    // 2 ns glitch train, then low.
    @(posedge clk);
    #1;
    for (int k = 0; k < 5; k++) begin
      sig_i = ~sig_i;
      #2;
    end
    sig_i = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    check("t2_sig16",  32'(sig_o[0]), 0);
    check("t2_sig4",   32'(sig_o[1]), 0);
    check("t2_strobe", rise_cnt[0] + rise_cnt[1] + fall_cnt[0] + fall_cnt[1], 0);

    // Stable high: first sampling edge is e0+1, output at edge 18 of that count.
    @(posedge clk);
    #1;
    sig_i = 1'b1;
    e0 = edge_no;
    b0 = rise_cnt[0];
    wait_rise(0, b0);
    check("t3_latency16", last_rise[0] - e0, 18);
    check("t3_latency4",  last_rise[1] - e0, 6);
    repeat (62) @(posedge clk);
    #1;
    check("t3_one_rise", rise_cnt[0] - b0, 1);
    check("t3_sig16",    32'(sig_o[0]), 1);

    // 5 ns dip between edges is invisible.
    fb0 = fall_cnt[0];
    fb1 = fall_cnt[1];
    @(posedge clk);
    #2 sig_i = 1'b0;
    #5 sig_i = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    check("t4_sig16",  32'(sig_o[0]), 1);
    check("t4_fall16", fall_cnt[0] - fb0, 0);
    check("t4_fall4",  fall_cnt[1] - fb1, 0);

    // DEB_CYCLES=4: a 3-clock low pulse is ignored, a 4-clock one passes.
    @(posedge clk);
    #1 sig_i = 1'b0;
    repeat (3) @(posedge clk);
    #1 sig_i = 1'b1;
    repeat (15) @(posedge clk);
    #1;
    check("t5_short_fall4", fall_cnt[1] - fb1, 0);
    @(posedge clk);
    #1 sig_i = 1'b0;
    e0 = edge_no;
    low_cnt = 0;
    repeat (4) @(posedge clk);
    #1 sig_i = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (sig_o[1] === 1'b0) low_cnt++;
    end
    #1;
    check("t5_fall4",      fall_cnt[1] - fb1, 1);
    check("t5_fall_edge4", last_fall[1] - e0, 6);
    check("t5_low_len4",   low_cnt, 4);
    check("t5_fall16",     fall_cnt[0] - fb0, 0);

    // Reset with the 16-cycle counter at 10, then full requalification.
    repeat (20) @(posedge clk);
    #1 sig_i = 1'b0;
    fb0 = fall_cnt[0];
    repeat (12) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("t6_sig16_rst", 32'(sig_o[0]), 0);
    check("t6_sig4_rst",  32'(sig_o[1]), 0);
    sig_i = 1'b1;
    @(posedge clk);
    #3 rst_n = 1'b1;
    e0 = edge_no;
    b0 = rise_cnt[0];
    b1 = rise_cnt[1];
    wait_rise(0, b0);
    check("t6_no_fall16",  fall_cnt[0] - fb0, 0);
    check("t6_latency16",  last_rise[0] - e0, 18);
    check("t6_latency4",   last_rise[1] - e0, 6);
    check("t6_rises4",     rise_cnt[1] - b1, 1);

    // Random runs with occasional intra-cycle glitches and resets.
    repeat (150) begin
      v   = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 24);
      @(posedge clk);
      #($urandom_range(1, 7));
      sig_i = v;
      if ($urandom_range(0, 3) == 0) begin
        #1 sig_i = !v;
        #1 sig_i = v;
      end
      repeat (len - 1) @(posedge clk);
      if ($urandom_range(0, 40) == 0) begin
        @(posedge clk);
        #3 rst_n = 1'b0;
        #4 rst_n = 1'b1;
      end
    end

    repeat (5) @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
